// File: rtl/unidade_multiplicacao_if.sv
// unidade_multiplicacao_if -- handshake and data bus of the multiply unit.
//
// Groups the start request, operands and destination index (master -> slave)
// with the busy/done status, product, flags and register-file write port
// (slave -> master). CLK and RST are not part of the bundle.
//
// Optional feature macro: MULT_ACC_EN adds CTRLAcumula and Acumulador (MLA).
//
// Signals:
//   Inicio          start request
//   Operando1/2     multiplicand / multiplier
//   RDEntrada       destination register index
//   CTRLAcumula     accumulate select        (MULT_ACC_EN only)
//   Acumulador      MLA addend               (MULT_ACC_EN only)
//   Ocupado         operation in progress
//   Pronto          one-cycle completion pulse
//   Resultado       product (register-file write data)
//   RDSaida         destination index (register-file write address)
//   CTRLEscritaReg  register-file write enable
//   FlagN, FlagZ    sign and zero of Resultado
interface unidade_multiplicacao_if #(
  parameter int unsigned LARGURA = 32
);

  logic               Inicio;
  logic [LARGURA-1:0] Operando1;
  logic [LARGURA-1:0] Operando2;
  logic [4:0]         RDEntrada;
`ifdef MULT_ACC_EN
  logic               CTRLAcumula;
  logic [LARGURA-1:0] Acumulador;
`endif
  logic               Ocupado;
  logic               Pronto;
  logic [LARGURA-1:0] Resultado;
  logic [4:0]         RDSaida;
  logic               CTRLEscritaReg;
  logic               FlagN;
  logic               FlagZ;

`ifdef MULT_ACC_EN
  modport master (
    output Inicio, Operando1, Operando2, RDEntrada, CTRLAcumula, Acumulador,
    input  Ocupado, Pronto, Resultado, RDSaida, CTRLEscritaReg, FlagN, FlagZ
  );

  modport slave (
    input  Inicio, Operando1, Operando2, RDEntrada, CTRLAcumula, Acumulador,
    output Ocupado, Pronto, Resultado, RDSaida, CTRLEscritaReg, FlagN, FlagZ
  );
`else
  modport master (
    output Inicio, Operando1, Operando2, RDEntrada,
    input  Ocupado, Pronto, Resultado, RDSaida, CTRLEscritaReg, FlagN, FlagZ
  );

  modport slave (
    input  Inicio, Operando1, Operando2, RDEntrada,
    output Ocupado, Pronto, Resultado, RDSaida, CTRLEscritaReg, FlagN, FlagZ
  );
`endif

endinterface

// File: rtl/unidade_multiplicacao.sv
// unidade_multiplicacao -- iterative 32x32 shift-and-add multiplier.
//
// Accepts an operation in OCIOSO when Inicio is high, then spends exactly 32
// CALCULA cycles adding the shifted multiplicand for each set multiplier bit.
// The low 32 bits of the product (plus the optional addend) are registered
// together with FlagN/FlagZ/RDSaida on entry to FIM, where Pronto and
// CTRLEscritaReg pulse for one cycle. Latency is fixed; there is no early exit.
//
// Optional feature macro: MULT_ACC_EN -- when defined the accumulator loads
// Acumulador on acceptance if CTRLAcumula is high (MLA), otherwise zero (MUL).
//
// Ports:
//   CLK  clock, all state on rising edge
//   RST  synchronous active-high reset; aborts any operation without Pronto
//   mult slave side of unidade_multiplicacao_if (see interface header)
module unidade_multiplicacao #(
  parameter int unsigned LARGURA = 32
) (
  input logic                   CLK,
  input logic                   RST,
  unidade_multiplicacao_if.slave mult
);

  // Only the 32-bit datapath is supported.
  if (LARGURA != 32) begin : g_largura_invalida
    $error("unidade_multiplicacao: LARGURA must be 32");
  end

  typedef enum logic [1:0] {
    StOcioso  = 2'd0,
    StCalcula = 2'd1,
    StFim     = 2'd2
  } estado_e;

  estado_e            estado_q;
  logic [LARGURA-1:0] multiplicando_q;
  logic [LARGURA-1:0] multiplicador_q;
  logic [LARGURA-1:0] acumulador_q;
  logic [4:0]         contador_q;
  logic [4:0]         rd_q;

  // Registered outputs
  logic               ocupado_q;
  logic               pronto_q;
  logic [LARGURA-1:0] resultado_q;
  logic [4:0]         rd_saida_q;
  logic               flag_n_q;
  logic               flag_z_q;

  logic [LARGURA-1:0] parcela;
  logic [LARGURA-1:0] soma;
  logic [LARGURA-1:0] carga_acumulador;

  // One shift-and-add step; the sum of the last step is also the final result.
  always_comb begin
    parcela = '0;
    if (multiplicador_q[0]) begin
      parcela = multiplicando_q;
    end
    soma = acumulador_q + parcela;
  end

  // Initial accumulator value on acceptance: addend for MLA, zero for MUL.
  always_comb begin
    carga_acumulador = '0;
`ifdef MULT_ACC_EN
    if (mult.CTRLAcumula) begin
      carga_acumulador = mult.Acumulador;
    end
`endif
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      estado_q        <= StOcioso;
      multiplicando_q <= '0;
      multiplicador_q <= '0;
      acumulador_q    <= '0;
      contador_q      <= '0;
      rd_q            <= '0;
      ocupado_q       <= 1'b0;
      pronto_q        <= 1'b0;
      resultado_q     <= '0;
      rd_saida_q      <= '0;
      flag_n_q        <= 1'b0;
      flag_z_q        <= 1'b0;
    end else begin
      case (estado_q)
        StOcioso: begin
          if (mult.Inicio) begin
            multiplicando_q <= mult.Operando1;
            multiplicador_q <= mult.Operando2;
            rd_q            <= mult.RDEntrada;
            acumulador_q    <= carga_acumulador;
            contador_q      <= '0;
            ocupado_q       <= 1'b1;
            estado_q        <= StCalcula;
          end
        end

        StCalcula: begin
          acumulador_q    <= soma;
          multiplicando_q <= multiplicando_q << 1;
          multiplicador_q <= multiplicador_q >> 1;
          contador_q      <= contador_q + 5'd1;
          // 32nd step: counter about to wrap 31 -> 0.
          if (contador_q == 5'd31) begin
            resultado_q <= soma;
            flag_n_q    <= soma[LARGURA-1];
            flag_z_q    <= (soma == '0);
            rd_saida_q  <= rd_q;
            pronto_q    <= 1'b1;
            estado_q    <= StFim;
          end
        end

        StFim: begin
          // Inicio seen here is dropped, not queued.
          pronto_q  <= 1'b0;
          ocupado_q <= 1'b0;
          estado_q  <= StOcioso;
        end

        default: begin
          pronto_q  <= 1'b0;
          ocupado_q <= 1'b0;
          estado_q  <= StOcioso;
        end
      endcase
    end
  end

  assign mult.Ocupado        = ocupado_q;
  assign mult.Pronto         = pronto_q;
  assign mult.CTRLEscritaReg = pronto_q;
  assign mult.Resultado      = resultado_q;
  assign mult.RDSaida        = rd_saida_q;
  assign mult.FlagN          = flag_n_q;
  assign mult.FlagZ          = flag_z_q;

  // Pronto only ever appears in FIM, and Ocupado tracks the non-idle states.
  a_pronto_em_fim : assert property (@(posedge CLK) disable iff (RST)
    pronto_q |-> (estado_q == StFim));
  a_ocupado_estado : assert property (@(posedge CLK) disable iff (RST)
    ocupado_q == (estado_q != StOcioso));

endmodule
